// File: rtl/apb2axi_pkg.sv
// Shared types and default sizing for the APB-to-AXI outstanding-command directory.
package apb2axi_pkg;

    localparam int AXI_ADDR_W  = 40;
    localparam int DIR_ENTRIES = 8;
    localparam int TAG_W       = $clog2(DIR_ENTRIES);

    typedef enum logic [1:0] {
        FREE    = 2'd0,
        PENDING = 2'd1,
        ISSUED  = 2'd2,
        DONE    = 2'd3
    } dir_state_e;

    // The address lives in a separately sized array so it can follow the
    // AXI_ADDR_W override of the directory; everything else is per-slot here.
    typedef struct packed {
        dir_state_e  state;
        logic [7:0]  len;
        logic [2:0]  size;
        logic        is_write;
        logic        err;
    } dir_entry_t;

endpackage

// File: rtl/apb2axi_tag_fifo.sv
// Tag FIFO holding slot indices in commit order until the AXI issue stage takes them.
module apb2axi_tag_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         empty,
    output logic [W-1:0] head
);
    import apb2axi_pkg::*;

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] mem_d [DEPTH];
    logic [PW:0]  wr_q, wr_d;
    logic [PW:0]  rd_q, rd_d;

    // Pointers carry one extra wrap bit so equal pointers unambiguously mean empty.
    assign empty = (wr_q == rd_q);
    assign head  = mem_q[rd_q[PW-1:0]];

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        if (push) begin
            mem_d[wr_q[PW-1:0]] = push_data;
            wr_d                = wr_q + (PW+1)'(1);
        end
        if (pop && !empty) begin
            rd_d = rd_q + (PW+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/apb2axi_directory.sv
// Outstanding-command directory: allocates slots on commit, issues them in commit
// order, tracks AXI completion, and frees them when software retires the slot.
module apb2axi_directory #(
    parameter int AXI_ADDR_W  = apb2axi_pkg::AXI_ADDR_W,
    parameter int DIR_ENTRIES = 8,
    parameter int TAG_W       = $clog2(DIR_ENTRIES)
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic                  commit_pulse,
    input  logic [AXI_ADDR_W-1:0] addr,
    input  logic [7:0]            len,
    input  logic [2:0]            size,
    input  logic                  is_write,
    output logic                  cmd_valid,
    input  logic                  cmd_ready,
    output logic [TAG_W-1:0]      cmd_tag,
    output logic [AXI_ADDR_W-1:0] cmd_addr,
    output logic [7:0]            cmd_len,
    output logic [2:0]            cmd_size,
    output logic                  cmd_is_write,
    input  logic                  cpl_valid,
    input  logic [TAG_W-1:0]      cpl_tag,
    input  logic                  cpl_err,
    input  logic                  ret_valid,
    input  logic [TAG_W-1:0]      ret_tag,
    input  logic [TAG_W-1:0]      sts_tag,
    output logic [1:0]            sts_state,
    output logic                  sts_err,
    output logic [TAG_W:0]        free_count,
    output logic                  full,
    output logic                  overflow,
    output logic                  proto_err
);
    import apb2axi_pkg::*;

    dir_entry_t            entry_q [DIR_ENTRIES];
    dir_entry_t            entry_d [DIR_ENTRIES];
    logic [AXI_ADDR_W-1:0] addr_q  [DIR_ENTRIES];
    logic [AXI_ADDR_W-1:0] addr_d  [DIR_ENTRIES];
    logic                  overflow_q, overflow_d;
    logic                  proto_err_q, proto_err_d;

    logic [TAG_W:0]   free_cnt;
    logic [TAG_W-1:0] alloc_tag;
    logic [TAG_W-1:0] head_tag;
    logic             have_free;
    logic             alloc;
    logic             pop;
    logic             fifo_empty;

    // Scan from the top so the last hit is the lowest FREE index. Only registered
    // state is looked at, so a slot retired this cycle is not allocatable yet.
    always_comb begin
        free_cnt  = '0;
        have_free = 1'b0;
        alloc_tag = '0;
        for (int i = DIR_ENTRIES - 1; i >= 0; i--) begin
            if (entry_q[i].state == FREE) begin
                free_cnt  = free_cnt + (TAG_W+1)'(1);
                have_free = 1'b1;
                alloc_tag = TAG_W'(i);
            end
        end
    end

    assign alloc      = commit_pulse && have_free;
    assign cmd_valid  = !fifo_empty;
    assign pop        = cmd_valid && cmd_ready;
    assign full       = !have_free;
    assign free_count = free_cnt;
    assign overflow   = overflow_q;
    assign proto_err  = proto_err_q;

    assign cmd_tag      = head_tag;
    assign cmd_addr     = addr_q[head_tag];
    assign cmd_len      = entry_q[head_tag].len;
    assign cmd_size     = entry_q[head_tag].size;
    assign cmd_is_write = entry_q[head_tag].is_write;

    assign sts_state = entry_q[sts_tag].state;
    assign sts_err   = entry_q[sts_tag].err;

    apb2axi_tag_fifo #(
        .DEPTH (DIR_ENTRIES),
        .W     (TAG_W)
    ) u_tag_fifo (
        .clk       (pclk),
        .rst       (preset),
        .push      (alloc),
        .push_data (alloc_tag),
        .pop       (pop),
        .empty     (fifo_empty),
        .head      (head_tag)
    );

    // Each event is gated by the slot's current state, and those states are
    // mutually exclusive, so alloc/pop/cpl/ret never write the same slot.
    always_comb begin
        entry_d     = entry_q;
        addr_d      = addr_q;
        overflow_d  = overflow_q;
        proto_err_d = proto_err_q;

        if (commit_pulse && !have_free) begin
            overflow_d = 1'b1;
        end
        if (alloc) begin
            entry_d[alloc_tag].state    = PENDING;
            entry_d[alloc_tag].len      = len;
            entry_d[alloc_tag].size     = size;
            entry_d[alloc_tag].is_write = is_write;
            entry_d[alloc_tag].err      = 1'b0;
            addr_d[alloc_tag]           = addr;
        end
        if (pop) begin
            entry_d[head_tag].state = ISSUED;
        end
        if (cpl_valid) begin
            if (entry_q[cpl_tag].state == ISSUED) begin
                entry_d[cpl_tag].state = DONE;
                entry_d[cpl_tag].err   = cpl_err;
            end else begin
                proto_err_d = 1'b1;
            end
        end
        if (ret_valid) begin
            if (entry_q[ret_tag].state == DONE) begin
                entry_d[ret_tag].state = FREE;
                entry_d[ret_tag].err   = 1'b0;
            end else begin
                proto_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            overflow_q  <= 1'b0;
            proto_err_q <= 1'b0;
            for (int i = 0; i < DIR_ENTRIES; i++) begin
                entry_q[i] <= '0;
                addr_q[i]  <= '0;
            end
        end else begin
            overflow_q  <= overflow_d;
            proto_err_q <= proto_err_d;
            entry_q     <= entry_d;
            addr_q      <= addr_d;
        end
    end

endmodule
